// File: rtl/dabble_pkg.sv
// Shared types and constants for the BCD-to-binary (reverse double-dabble) converter.
package dabble_pkg;

  localparam int DIGIT_BITS = 4;

  typedef logic [DIGIT_BITS-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A packed BCD digit is only legal in the range 0..9.
  function automatic logic digit_invalid(input bcd_digit_t d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/dabble_reverse_sub3.sv
// Per-digit correction step of the reverse double-dabble: subtract 3 from any digit >= 8.
module sub3
  import dabble_pkg::*;
(
  input  logic [DIGIT_BITS-1:0] din,
  output logic [DIGIT_BITS-1:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/dabble_reverse.sv
// Iterative packed-BCD to binary converter, one shift/correct step per clock.
// Optional input digit checking is enabled by defining DABBLE_REVERSE_DIGIT_CHECK_EN.
module dabble_reverse
  import dabble_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int WIDTH_OUT  = 17
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DIGIT_BITS*NUM_DIGITS-1:0] bcd,
  output logic [WIDTH_OUT-1:0]           bin,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic                           err
);

  localparam int BCD_W = DIGIT_BITS * NUM_DIGITS;
  localparam int SCR_W = BCD_W + WIDTH_OUT;
  localparam int CNT_W = $clog2(WIDTH_OUT) + 1;

  state_t               state_q, state_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH_OUT-1:0] bin_q, bin_d;
  logic                 overflow_q, overflow_d;

  logic [SCR_W-1:0]     shifted;
  logic [BCD_W-1:0]     adjusted_bcd;
  logic [SCR_W-1:0]     iter_next;
  logic                 last_iter;
  logic                 accept;

  // One iteration: shift right, then correct every digit of the BCD field.
  assign shifted = scratch_q >> 1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    sub3 u_sub3 (
      .din  (shifted[WIDTH_OUT + gi*DIGIT_BITS +: DIGIT_BITS]),
      .dout (adjusted_bcd[gi*DIGIT_BITS +: DIGIT_BITS])
    );
  end

  assign iter_next = {adjusted_bcd, shifted[WIDTH_OUT-1:0]};
  assign last_iter = (cnt_q == CNT_W'(WIDTH_OUT - 1));
  assign accept    = start && (state_q != ST_RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_DONE;
      ST_DONE: if (start)     state_d = ST_RUN;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // Datapath: bcd is captured only on acceptance; bin moves only on the final iteration.
  always_comb begin
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    overflow_d = overflow_q;
    if (accept) begin
      scratch_d  = {bcd, {WIDTH_OUT{1'b0}}};
      cnt_d      = '0;
      overflow_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      scratch_d = iter_next;
      cnt_d     = cnt_q + CNT_W'(1);
      if (last_iter) begin
        bin_d      = iter_next[WIDTH_OUT-1:0];
        overflow_d = |iter_next[SCR_W-1:WIDTH_OUT];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q  <= '0;
      cnt_q      <= '0;
      bin_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      overflow_q <= overflow_d;
    end
  end

  assign bin      = bin_q;
  assign overflow = overflow_q;

`ifdef DABBLE_REVERSE_DIGIT_CHECK_EN
  logic [NUM_DIGITS-1:0] digit_bad;
  logic                  err_q, err_d;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_check
    assign digit_bad[gi] = digit_invalid(bcd[gi*DIGIT_BITS +: DIGIT_BITS]);
  end

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = |digit_bad;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dabble_reverse.sv
// Directed bench for dabble_reverse: default instance (17-bit) and a 16-bit instance for overflow cases.
module tb_dabble_reverse;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_a, reset_b, start_a, start_b;
  logic [19:0] bcd_a, bcd_b;
  logic [16:0] bin_a;
  logic [15:0] bin_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b, err_a, err_b;

  dabble_reverse u_dut_a (
    .clock    (clock),
    .reset    (reset_a),
    .start    (start_a),
    .bcd      (bcd_a),
    .bin      (bin_a),
    .busy     (busy_a),
    .done     (done_a),
    .overflow (ovf_a),
    .err      (err_a)
  );

  dabble_reverse #(.NUM_DIGITS(5), .WIDTH_OUT(16)) u_dut_b (
    .clock    (clock),
    .reset    (reset_b),
    .start    (start_b),
    .bcd      (bcd_b),
    .bin      (bin_b),
    .busy     (busy_b),
    .done     (done_b),
    .overflow (ovf_b),
    .err      (err_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          sel;
    logic [19:0] bcd;
    logic [16:0] bin;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

`ifdef DABBLE_REVERSE_DIGIT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [31:0] cur_bin(input int sel);
    return (sel != 0) ? 32'(bin_b) : 32'(bin_a);
  endfunction

  task automatic launch(input int sel, input logic [19:0] v);
    if (sel != 0) begin
      bcd_b = v; start_b = 1'b1;
    end else begin
      bcd_a = v; start_a = 1'b1;
    end
    @(posedge clock); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    while (!((sel != 0) ? done_b : done_a) && cyc < 100) begin
      if ((sel != 0) ? busy_b : busy_a) bc++;
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc, bc, width;
    logic [31:0] prev_bin;

    vecs[0] = '{0, 20'h12345, 17'h03039, 1'b0};
    vecs[1] = '{0, 20'h99999, 17'h1869F, 1'b0};
    vecs[2] = '{0, 20'h00000, 17'h00000, 1'b0};
    vecs[3] = '{1, 20'h65536, 17'h00000, 1'b1};
    vecs[4] = '{1, 20'h65535, 17'h0FFFF, 1'b0};
    vecs[5] = '{0, 20'h00001, 17'h00001, 1'b0};
    vecs[6] = '{0, 20'h10000, 17'h02710, 1'b0};
    vecs[7] = '{1, 20'h00009, 17'h00009, 1'b0};

    reset_a = 1'b1; reset_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    bcd_a = '0; bcd_b = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_a = 1'b0; reset_b = 1'b0;

    chk("reset_bin",  cur_bin(0), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);
    chk("reset_done", 32'(done_a), 32'h0);
    chk("reset_ovf",  32'(ovf_a),  32'h0);
    chk("reset_err",  32'(err_a),  32'h0);

    foreach (vecs[i]) begin
      width = (vecs[i].sel != 0) ? 16 : 17;
      launch(vecs[i].sel, vecs[i].bcd);
      chk($sformatf("v%0d_ovf_clear", i), 32'((vecs[i].sel != 0) ? ovf_b : ovf_a), 32'h0);
      wait_done(vecs[i].sel, cyc, bc);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(width));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(width));
      chk($sformatf("v%0d_bin", i), cur_bin(vecs[i].sel), 32'(vecs[i].bin));
      chk($sformatf("v%0d_ovf", i), 32'((vecs[i].sel != 0) ? ovf_b : ovf_a), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_err", i), 32'((vecs[i].sel != 0) ? err_b : err_a), 32'h0);
    end

    // DONE holds without start
    repeat (3) @(posedge clock);
    #1;
    chk("done_hold", 32'(done_a), 32'h1);

    // start re-pulsed at cycle 5 of RUN with a different bcd is ignored
    prev_bin = cur_bin(0);
    launch(0, 20'h12345);
    repeat (4) @(posedge clock);
    #1;
    bcd_a = 20'h00001; start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    chk("ign_busy", 32'(busy_a), 32'h1);
    chk("ign_bin_hold", cur_bin(0), prev_bin);
    wait_done(0, cyc, bc);
    chk("ign_remaining", 32'(cyc), 32'd12);
    chk("ign_bin", cur_bin(0), 32'h03039);

    // reset at cycle 8 of RUN aborts the conversion
    launch(0, 20'h99999);
    repeat (7) @(posedge clock);
    #1;
    reset_a = 1'b1;
    @(posedge clock); #1;
    reset_a = 1'b0;
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_bin",  cur_bin(0), 32'h0);
    repeat (20) @(posedge clock);
    #1;
    chk("rst_idle_no_done", 32'(done_a), 32'h0);
    chk("rst_idle_bin", cur_bin(0), 32'h0);
    launch(0, 20'h12345);
    wait_done(0, cyc, bc);
    chk("rst_restart_latency", 32'(cyc), 32'd17);
    chk("rst_restart_bin", cur_bin(0), 32'h03039);

    // illegal digit: err only when the check is built in
    launch(0, 20'h0A123);
    wait_done(0, cyc, bc);
    chk("bad_digit_latency", 32'(cyc), 32'd17);
    chk("bad_digit_err", 32'(err_a), 32'(ERR_EXP));
    launch(0, 20'h00042);
    wait_done(0, cyc, bc);
    chk("err_clear", 32'(err_a), 32'h0);
    chk("after_err_bin", cur_bin(0), 32'h0002A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
